// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode/funct3 constants, control bundle and FSM state types
package decode_stage_pkg;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I1 = 7'b0000011;
  localparam logic [6:0] OPC_I2 = 7'b0010011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_B  = 7'b1100011;
  localparam logic [6:0] OPC_J  = 7'b1101111;

  localparam logic [2:0] F3_LDB = 3'b000;
  localparam logic [2:0] F3_STB = 3'b000;

  typedef struct packed {
    logic y_sel;
    logic write;
    logic read_mmu;
    logic write_mmu;
    logic byte_sel;
    logic branch;
    logic load;
    logic jump;
    logic illegal;
  } ctrl_t;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

endpackage

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - combinational instruction decoder: op bundle, immediate, flags, source use
module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 14
) (
  input  logic [31:0]     i_ir,
  output logic [OPW-1:0]  o_op,
  output logic [XLEN-1:0] o_immed,
  output ctrl_t           o_ctrl,
  output logic            o_use_rs1,
  output logic            o_use_rs2
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;

  assign w_opc = i_ir[6:0];
  assign w_f3  = i_ir[14:12];
  assign w_f7  = i_ir[31:25];

  assign w_imm_i = {{(XLEN-12){i_ir[31]}}, i_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
  assign w_imm_b = {{(XLEN-13){i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-21){i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};

  always_comb begin
    o_op      = '0;
    o_immed   = '0;
    o_ctrl    = '0;
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    case (w_opc)
      OPC_R: begin
        o_op         = OPW'({w_opc, w_f7});
        o_ctrl.y_sel = 1'b1;
        o_ctrl.write = 1'b1;
        o_use_rs1    = 1'b1;
        o_use_rs2    = 1'b1;
      end
      OPC_I1: begin
        o_op            = OPW'({w_opc, 4'b0, w_f3});
        o_immed         = w_imm_i;
        o_ctrl.write    = 1'b1;
        o_ctrl.read_mmu = 1'b1;
        o_ctrl.load     = 1'b1;
        o_ctrl.byte_sel = (w_f3 == F3_LDB);
        o_use_rs1       = 1'b1;
      end
      OPC_I2: begin
        o_op         = OPW'({w_opc, 4'b0, w_f3});
        o_immed      = w_imm_i;
        o_ctrl.write = 1'b1;
        o_use_rs1    = 1'b1;
      end
      OPC_S: begin
        o_op             = OPW'({w_opc, 4'b0, w_f3});
        o_immed          = w_imm_s;
        o_ctrl.write_mmu = 1'b1;
        o_ctrl.byte_sel  = (w_f3 == F3_STB);
        o_use_rs1        = 1'b1;
        o_use_rs2        = 1'b1;
      end
      OPC_B: begin
        o_op          = OPW'({w_opc, 4'b0, w_f3});
        o_immed       = w_imm_b;
        o_ctrl.y_sel  = 1'b1;
        o_ctrl.branch = 1'b1;
        o_use_rs1     = 1'b1;
        o_use_rs2     = 1'b1;
      end
      OPC_J: begin
        o_op         = OPW'({w_opc, 7'b0});
        o_immed      = w_imm_j;
        o_ctrl.write = 1'b1;
        o_ctrl.jump  = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage: load-use hazard, valid/ready handshake, bubble counter
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int OPW   = 14,
  parameter int CNTW  = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [OPW-1:0]  out_op,
  output logic [RW-1:0]   out_addr_a,
  output logic [RW-1:0]   out_addr_b,
  output logic [RW-1:0]   out_addr_d,
  output logic [XLEN-1:0] out_immed,
  output logic [XLEN-1:0] out_pc,
  output logic            out_y_sel,
  output logic            out_write,
  output logic            out_read_mmu,
  output logic            out_write_mmu,
  output logic            out_byte_sel,
  output logic            out_branch,
  output logic            out_load,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [CNTW-1:0] bubble_count
);

  logic [OPW-1:0]  w_op;
  logic [XLEN-1:0] w_immed;
  ctrl_t           w_ctrl;
  logic            w_use_rs1, w_use_rs2;
  logic [RW-1:0]   w_rs1, w_rs2, w_rd;
  logic            w_hazard, w_accept, w_fire;

  state_t          r_state;
  logic [OPW-1:0]  r_op;
  logic [RW-1:0]   r_addr_a, r_addr_b, r_addr_d;
  logic [XLEN-1:0] r_immed, r_pc;
  ctrl_t           r_ctrl;
  logic [CNTW-1:0] r_bubbles;

  decode_logic #(.XLEN(XLEN), .OPW(OPW)) u_decode (
    .i_ir      (in_ir),
    .o_op      (w_op),
    .o_immed   (w_immed),
    .o_ctrl    (w_ctrl),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  assign w_rs1 = in_ir[15 +: RW];
  assign w_rs2 = in_ir[20 +: RW];
  assign w_rd  = in_ir[7 +: RW];

  // A load still sitting in the register cannot forward to a consumer entering now.
  assign w_hazard = out_valid && r_ctrl.load && (r_addr_d != '0) && in_valid &&
                    ((w_use_rs1 && (w_rs1 == r_addr_d)) || (w_use_rs2 && (w_rs2 == r_addr_d)));

  assign in_ready = !reset && !flush && !w_hazard && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_op      <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_d  <= '0;
      r_immed   <= '0;
      r_pc      <= '0;
      r_ctrl    <= '0;
      r_bubbles <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      if (w_accept) begin
        r_op     <= w_op;
        r_addr_a <= w_rs1;
        r_addr_b <= w_rs2;
        r_addr_d <= w_rd;
        r_immed  <= w_immed;
        r_pc     <= in_pc;
        r_ctrl   <= w_ctrl;
      end
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_FULL;
        ST_FULL: if (w_fire) begin
          r_state <= w_accept ? ST_FULL : ST_EMPTY;
          if (w_hazard && (r_bubbles != '1)) r_bubbles <= r_bubbles + CNTW'(1);
        end
      endcase
    end
  end

  assign out_valid     = (r_state == ST_FULL);
  assign out_op        = r_op;
  assign out_addr_a    = r_addr_a;
  assign out_addr_b    = r_addr_b;
  assign out_addr_d    = r_addr_d;
  assign out_immed     = r_immed;
  assign out_pc        = r_pc;
  assign out_y_sel     = r_ctrl.y_sel;
  assign out_write     = r_ctrl.write;
  assign out_read_mmu  = r_ctrl.read_mmu;
  assign out_write_mmu = r_ctrl.write_mmu;
  assign out_byte_sel  = r_ctrl.byte_sel;
  assign out_branch    = r_ctrl.branch;
  assign out_load      = r_ctrl.load;
  assign out_jump      = r_ctrl.jump;
  assign out_illegal   = r_ctrl.illegal;
  assign bubble_count  = r_bubbles;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with directed and random stimulus
module tb_decode_stage;

  localparam int CNTW = 3;

  typedef struct packed {
    logic [13:0] op;
    logic [4:0]  a, b, d;
    logic [31:0] imm, pc;
    logic [8:0]  fl;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = '0, in_pc = '0;
  logic in_ready, out_valid;
  logic [13:0] out_op;
  logic [4:0] out_addr_a, out_addr_b, out_addr_d;
  logic [31:0] out_immed, out_pc;
  logic out_y_sel, out_write, out_read_mmu, out_write_mmu, out_byte_sel;
  logic out_branch, out_load, out_jump, out_illegal;
  logic [CNTW-1:0] bubble_count;

  int n_vec = 0, n_err = 0;
  rec_t q[$];
  int exp_cnt = 0;
  logic after_rst = 1'b0, last_acc = 1'b0;
  logic [31:0] pc_ctr = 32'h1000;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32), .OPW(14), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_op(out_op), .out_addr_a(out_addr_a),
    .out_addr_b(out_addr_b), .out_addr_d(out_addr_d), .out_immed(out_immed),
    .out_pc(out_pc), .out_y_sel(out_y_sel), .out_write(out_write),
    .out_read_mmu(out_read_mmu), .out_write_mmu(out_write_mmu),
    .out_byte_sel(out_byte_sel), .out_branch(out_branch), .out_load(out_load),
    .out_jump(out_jump), .out_illegal(out_illegal), .bubble_count(bubble_count)
  );

  rec_t act;
  assign act = '{op: out_op, a: out_addr_a, b: out_addr_b, d: out_addr_d,
                 imm: out_immed, pc: out_pc,
                 fl: {out_y_sel, out_write, out_read_mmu, out_write_mmu, out_byte_sel,
                      out_branch, out_load, out_jump, out_illegal}};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference decode, built arithmetically from the format rules.
  function automatic rec_t ref_dec(input logic [31:0] ir, input logic [31:0] pc);
    rec_t r;
    logic [31:0] sx;
    sx = ir[31] ? 32'hFFFF_FFFF : 32'h0;
    r = '0;
    r.a = ir[19:15]; r.b = ir[24:20]; r.d = ir[11:7]; r.pc = pc;
    case (ir[6:0])
      7'h33: begin r.op = {ir[6:0], ir[31:25]}; r.fl = 9'b110000000; end
      7'h03: begin
        r.op = {ir[6:0], 4'b0, ir[14:12]}; r.imm = (sx << 12) | 32'(ir[31:20]);
        r.fl = {1'b0, 1'b1, 1'b1, 1'b0, ir[14:12] == 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
      end
      7'h13: begin
        r.op = {ir[6:0], 4'b0, ir[14:12]}; r.imm = (sx << 12) | 32'(ir[31:20]);
        r.fl = 9'b010000000;
      end
      7'h23: begin
        r.op = {ir[6:0], 4'b0, ir[14:12]};
        r.imm = (sx << 12) | (32'(ir[31:25]) << 5) | 32'(ir[11:7]);
        r.fl = {4'b0001, ir[14:12] == 3'b000, 4'b0000};
      end
      7'h63: begin
        r.op = {ir[6:0], 4'b0, ir[14:12]};
        r.imm = (sx << 12) | (32'(ir[7]) << 11) | (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
        r.fl = 9'b100001000;
      end
      7'h6F: begin
        r.op = {ir[6:0], 7'b0};
        r.imm = (sx << 20) | (32'(ir[19:12]) << 12) | (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
        r.fl = 9'b010000010;
      end
      default: r.fl = 9'b000000001;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] reads(input logic [31:0] ir);
    case (ir[6:0])
      7'h33, 7'h23, 7'h63: return 2'b11;
      7'h03, 7'h13:        return 2'b10;
      default:             return 2'b00;
    endcase
  endfunction

  // Issue side: checks handshake/counter against the model and pushes accepted work.
  task automatic step();
    logic hz, rdy;
    logic [1:0] u;
    if (after_rst) chk("reset_outputs", {out_valid, act, bubble_count}, '0);
    chk("out_valid", out_valid, q.size() != 0);
    chk("bubble_count", bubble_count, exp_cnt[CNTW-1:0]);
    u = reads(in_ir);
    hz = (q.size() != 0) && q[0].fl[2] && (q[0].d != 0) && in_valid &&
         ((u[1] && in_ir[19:15] == q[0].d) || (u[0] && in_ir[24:20] == q[0].d));
    rdy = !reset && !flush && !hz && ((q.size() == 0) || out_ready);
    chk("in_ready", in_ready, rdy);
    last_acc = in_valid && rdy;
    if (reset) begin
      q.delete(); exp_cnt = 0; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (flush) begin
        if (q.size() != 0) void'(q.pop_front());
      end else begin
        if ((q.size() != 0) && out_ready && hz && exp_cnt < (1 << CNTW) - 1) exp_cnt++;
        if (last_acc) q.push_back(ref_dec(in_ir, in_pc));
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic ordy,
                       input logic fl, input logic rst);
    @(posedge clk); #1;
    in_valid = v; in_ir = ir; in_pc = pc_ctr; out_ready = ordy; flush = fl; reset = rst;
    @(negedge clk);
    step();
    if (last_acc) pc_ctr = pc_ctr + 4;
  endtask

  task automatic send(input logic [31:0] ir);
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, ir, 1'b1, 1'b0, 1'b0);
      if (last_acc) break;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_ir();
    logic [31:0] ir;
    logic [6:0] opcs [7];
    opcs = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h00};
    ir = $urandom;
    ir[6:0] = opcs[$urandom_range(0, 6)];
    if (ir[6:0] == 7'h00) ir[6:0] = 7'($urandom_range(0, 127));
    ir[19:15] = 5'($urandom_range(0, 3));
    ir[24:20] = 5'($urandom_range(0, 3));
    ir[11:7]  = 5'($urandom_range(0, 3));
    return ir;
  endfunction

  // Monitor: compares the held bundle on every valid cycle, pops when it is consumed.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!reset && !flush && out_valid) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          chk("bundle", act, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    send(32'h002081B3); send(32'hFFF18213); idle(2);
    send(32'h0080A283); send(32'h00228333); idle(2);
    send(32'h0080A003); send(32'h00200333); idle(2);
    send(32'h00208023);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
    idle(2);
    send(32'h002081B3);
    drive(1'b1, 32'hFFF18213, 1'b1, 1'b1, 1'b0);
    idle(2);
    send(32'h80000063); send(32'h0020006F); send(32'h0000007F); idle(2);
    send(32'h0080A283); send(32'h002081B3);
    drive(1'b1, 32'h00228333, 1'b1, 1'b0, 1'b1);
    send(32'h002081B3); send(32'hFFF18213); idle(2);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, rnd_ir(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    idle(4);
    chk("drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
